// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT = 4;
    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned NUM_REGS         = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// FIFO of deferred multdiv results with per-entry kill on a newer pipeline write,
// plus the per-register pending vector derived from live entries.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned Depth = WB_DEPTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  enq_i,
    input  logic [REG_ADDR_W-1:0] enq_rd_i,
    input  logic [DATA_W-1:0]     enq_data_i,
    input  logic                  deq_i,
    input  logic                  squash_i,
    input  logic [REG_ADDR_W-1:0] squash_rd_i,
    output wb_entry_t             head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [NUM_REGS-1:0]   pending_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_entry_t       mem_q [Depth];
    wb_entry_t       mem_d [Depth];
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;

        for (int i = 0; i < Depth; i++) begin
            if (squash_i && (mem_q[i].rd == squash_rd_i)) begin
                mem_d[i].live = 1'b0;
            end
        end

        // Popped slots are marked dead so they drop out of the pending vector.
        if (deq_i) begin
            mem_d[rptr_q].live = 1'b0;
            rptr_d             = rptr_q + PtrW'(1);
        end

        if (enq_i) begin
            mem_d[wptr_q] = wb_entry_t'{
                live: !(squash_i && (squash_rd_i == enq_rd_i)),
                rd:   enq_rd_i,
                data: enq_data_i
            };
            wptr_d = wptr_q + PtrW'(1);
        end

        unique case ({enq_i, deq_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (mem_q[i].live) begin
                pending_o[mem_q[i].rd] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: pipeline write-back first, then queued multdiv results.
// Optional WB_BYPASS_EN lets a multdiv result skip an empty, idle queue.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [NUM_REGS-1:0]   md_pending
);

    wb_entry_t             head;
    logic                  q_empty, q_full;
    logic                  md_accept, bypass, enq, deq, squash;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;

    assign md_ready  = !q_full;
    assign md_accept = md_valid && md_ready;
    assign squash    = pipe_we && (pipe_rd != '0);
    assign deq       = !q_empty && !pipe_we;

`ifdef WB_BYPASS_EN
    assign bypass = q_empty && !pipe_we && md_accept && (md_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Results for x0 are discarded at acceptance.
    assign enq = md_accept && (md_rd != '0) && !bypass;

    wb_queue #(
        .Depth (DEPTH)
    ) u_queue (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .enq_i        (enq),
        .enq_rd_i     (md_rd),
        .enq_data_i   (md_data),
        .deq_i        (deq),
        .squash_i     (squash),
        .squash_rd_i  (pipe_rd),
        .head_o       (head),
        .empty_o      (q_empty),
        .full_o       (q_full),
        .pending_o    (md_pending)
    );

    always_comb begin
        we_d   = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        if (pipe_we) begin
            // A write to x0 still occupies the port, blocking the queue.
            if (pipe_rd != '0) begin
                we_d   = 1'b1;
                reg_d  = pipe_rd;
                data_d = pipe_data;
            end
        end else if (bypass) begin
            we_d   = 1'b1;
            reg_d  = md_rd;
            data_d = md_data;
        end else if (deq && head.live) begin
            we_d   = 1'b1;
            reg_d  = head.rd;
            data_d = head.data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random stimulus for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] md_pending;

    wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .pipe_we          (pipe_we),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .md_pending       (md_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic check_all();
        chk("writeEnable", 32'(ctrl_writeEnable), 32'(exp_we));
        chk("writeReg", 32'(ctrl_writeReg), 32'(exp_reg));
        chk("writeData", data_writeReg, exp_data);
        chk("md_pending", md_pending, model_pending());
        chk("md_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
    endtask

    // One clock: drive inputs, advance the model by the rules, then compare after the edge.
    task automatic cyc(input bit pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mdata);
        bit     acc;
        bit     byp;
        m_ent_t h;
        pipe_we   = pwe;
        pipe_rd   = prd;
        pipe_data = pdata;
        md_valid  = mv;
        md_rd     = mrd;
        md_data   = mdata;
        acc = mv && (mq.size() < DEPTH);
`ifdef WB_BYPASS_EN
        byp = acc && !pwe && (mq.size() == 0) && (mrd != 0);
`else
        byp = 1'b0;
`endif
        if (pwe) begin
            exp_we = (prd != 0);
            if (prd != 0) begin
                exp_reg  = prd;
                exp_data = pdata;
            end
        end else if (byp) begin
            exp_we   = 1'b1;
            exp_reg  = mrd;
            exp_data = mdata;
        end else if (mq.size() > 0) begin
            h      = mq.pop_front();
            exp_we = h.live;
            if (h.live) begin
                exp_reg  = h.rd;
                exp_data = h.data;
            end
        end else begin
            exp_we = 1'b0;
        end
        if (pwe && prd != 0) begin
            foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
        end
        if (acc && mrd != 0 && !byp) begin
            mq.push_back('{rd: mrd, data: mdata, live: !(pwe && prd != 0 && prd == mrd)});
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Pipeline write, then a dropped x0 write.
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
        chk("pipe_write_data", data_writeReg, 32'hDEADBEEF);
        cyc(1, 0, 32'h11111111, 0, 0, 0);
        chk("pipe_x0_no_write", 32'(ctrl_writeEnable), 32'd0);

        // Queue latency for a single multdiv result.
        cyc(0, 0, 0, 1, 7, 32'h1234);
`ifndef WB_BYPASS_EN
        chk("pending7_set", 32'(md_pending[7]), 32'd1);
`endif
        idle(1);
        chk("md_write_reg7", 32'(ctrl_writeReg), 32'd7);
        idle(1);

        // Pipeline priority over a queued entry.
        cyc(1, 1, 32'h101, 1, 10, 32'hA0A0);
        cyc(1, 2, 32'h102, 0, 0, 0);
        cyc(1, 3, 32'h103, 0, 0, 0);
        idle(2);

        // Fill the queue while the pipeline is busy, then drain.
        for (int i = 0; i < 6; i++) cyc(1, 1, 32'h200 + i, 1, 5'(20 + i), 32'h300 + i);
        chk("full_not_ready", 32'(md_ready), 32'd0);
        idle(6);

        // Squash of a queued result by a newer pipeline write.
        cyc(1, 1, 32'h1, 1, 9, 32'hAAAA);
        cyc(1, 9, 32'h5555, 0, 0, 0);
        chk("pending9_clear", 32'(md_pending[9]), 32'd0);
        idle(3);

        // Asynchronous reset with entries in flight.
        for (int i = 0; i < 3; i++) cyc(1, 2, 32'h400 + i, 1, 5'(11 + i), 32'h500 + i);
        #2;
        pipe_we = 0; md_valid = 0;
        ctrl_reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;
        idle(5);

        // Random traffic; small rd range to exercise squash and x0 handling.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
        end
        idle(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
